key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 19 +
 rtl/sync_chain.sv | 28 ++
 rtl/key_conditioner.sv | 121 ++++++++++++
 tb/tb_key_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// key_pkg: FSM state encoding and default configuration shared by the key conditioner files.
// Rev 1.0
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 50;
  localparam int DEF_REPEAT_PERIOD   = 10;

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// sync_chain: STAGES-deep flop chain bringing an asynchronous level into the clk domain.
// Rev 1.0
module sync_chain
  import key_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// key_conditioner: synchronized, debounced key level with press/release pulses.
// Optional press auto-repeat while held: define KEY_AUTOREPEAT_EN. Rev 1.0
module key_conditioner
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press,
  output logic release_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_conditioner: illegal parameter set");
  end

  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          key_s;
  logic          stable_done;
  logic          rpt_fire;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (key_s)
  );

  // cnt is 0 in IDLE/HELD, so with DEBOUNCE_CYCLES=1 the first differing cycle is accepted at once
  assign stable_done = (cnt >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      key_level     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE, PRESS_WAIT: begin
          if (!key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (stable_done) begin
            state     <= HELD;
            cnt       <= '0;
            key_level <= 1'b1;
            press     <= 1'b1;
          end else begin
            state <= PRESS_WAIT;
            cnt   <= (state == IDLE) ? CW'(1) : cnt + 1'b1;
          end
        end
        HELD, RELEASE_WAIT: begin
          if (key_s) begin
            state <= HELD;
            cnt   <= '0;
            press <= rpt_fire;
          end else if (stable_done) begin
            state         <= IDLE;
            cnt           <= '0;
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            state <= RELEASE_WAIT;
            cnt   <= (state == HELD) ? CW'(1) : cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;
  logic [RW-1:0] rpt_goal;

  // First repeat waits REPEAT_DELAY from the press, later ones REPEAT_PERIOD from the previous
  assign rpt_goal = rpt_phase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
  assign rpt_fire = (state == HELD) && key_s && (rpt_cnt == rpt_goal - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || !key_level) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (state == HELD && key_s) begin
      if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// tb_key_conditioner: directed stimulus with a pulse scoreboard for key_conditioner.
// Rev 1.0
module tb_key_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;
  localparam int RDLY = 50;
  localparam int RPER = 10;

  typedef struct {
    int unsigned at;
    bit          is_press;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_raw = 1'b0;
  logic key_level;
  logic press;
  logic release_pulse;

  int unsigned edges  = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];

  key_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_raw       (key_raw),
    .key_level     (key_level),
    .press         (press),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic expect_ev(input int unsigned at, input bit p);
    ev_t e;
    e.at       = at;
    e.is_press = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic drive(input logic v);
    @(negedge clk);
    key_raw = v;
  endtask

  task automatic check_level(input string tag, input logic want);
    checks++;
    assert (key_level === want) else begin
      errors++;
      $error("FAIL %s: key_level=%b required=%b at edge %0d", tag, key_level, want, edges);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    ev_t ev;
    if (press === 1'b1 || release_pulse === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: press=%b release=%b at edge %0d, required none", press, release_pulse, edges);
      end
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        checks += 2;
        assert (edges === ev.at) else begin
          errors++;
          $error("FAIL pulse_time: observed edge %0d, required edge %0d", edges, ev.at);
        end
        assert (press === ev.is_press) else begin
          errors++;
          $error("FAIL pulse_kind: press=%b release=%b, required press=%b", press, release_pulse, ev.is_press);
        end
      end
    end
    if (!rst) begin
      checks++;
      assert (!(press === 1'b1 && release_pulse === 1'b1)) else begin
        errors++;
        $error("FAIL pulse_overlap: press=%b release=%b at edge %0d, required not both", press, release_pulse, edges);
      end
    end
  end

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      checks++;
      assert ({key_level, press, release_pulse} === 3'b000) else begin
        errors++;
        $error("FAIL reset_outputs: {level,press,release}=%b required 000", {key_level, press, release_pulse});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(5);
    check_level("idle_level", 1'b0);

    // Clean press held 20 cycles: level rises exactly LAT edges after sampling
    drive(1'b1);
    expect_ev(edges + LAT, 1'b1);
    wait_cyc(LAT - 1);
    check_level("press_before_latency", 1'b0);
    wait_cyc(1);
    check_level("press_at_latency", 1'b1);
    wait_cyc(20 - LAT);
    check_level("press_held", 1'b1);

    // Clean release held 20 cycles
    drive(1'b0);
    expect_ev(edges + LAT, 1'b0);
    wait_cyc(LAT - 1);
    check_level("release_before_latency", 1'b1);
    wait_cyc(1);
    check_level("release_at_latency", 1'b0);
    wait_cyc(20 - LAT);

    // 3-cycle glitch: shorter than DEB, must be ignored
    drive(1'b1);
    wait_cyc(2);
    drive(1'b0);
    wait_cyc(15);
    check_level("glitch_ignored", 1'b0);

    // Bouncy press 1,0,1,0 then stable 1: one press timed from the last rise
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    expect_ev(edges + LAT, 1'b1);
    wait_cyc(20);
    check_level("bouncy_press_held", 1'b1);
    drive(1'b0);
    expect_ev(edges + LAT, 1'b0);
    wait_cyc(20);
    check_level("bouncy_released", 1'b0);

    // Reset while HELD with key still pressed: no release, fresh press afterwards
    drive(1'b1);
    expect_ev(edges + LAT, 1'b1);
    wait_cyc(LAT + 5);
    check_level("pre_reset_held", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(1);
    checks++;
    assert ({key_level, press, release_pulse} === 3'b000) else begin
      errors++;
      $error("FAIL reset_in_held: {level,press,release}=%b required 000", {key_level, press, release_pulse});
    end
    wait_cyc(2);
    @(negedge clk);
    rst = 1'b0;
    expect_ev(edges + LAT, 1'b1);
    wait_cyc(LAT - 1);
    check_level("post_reset_before_latency", 1'b0);
    wait_cyc(1);
    check_level("post_reset_press", 1'b1);
    wait_cyc(10);
    drive(1'b0);
    expect_ev(edges + LAT, 1'b0);
    wait_cyc(20);
    check_level("post_reset_released", 1'b0);

`ifdef KEY_AUTOREPEAT_EN
    // Held 100 cycles: press at t0, then t0+50 and every 10 cycles after
    drive(1'b1);
    begin
      int unsigned t0;
      t0 = edges + LAT;
      expect_ev(t0, 1'b1);
      for (int k = 0; k < 5; k++) expect_ev(t0 + RDLY + RPER * k, 1'b1);
    end
    wait_cyc(99);
    drive(1'b0);
    expect_ev(edges + LAT, 1'b0);
    wait_cyc(25);
    check_level("autorepeat_released", 1'b0);
`endif

    wait_cyc(5);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
